// File: rtl/cl_systolic_sequencer.sv
// rtl/cl_systolic_sequencer.sv - A-operand BRAM compute-phase sequencer; define CL_SEQ_PERF_EN for perf counters
module cl_systolic_sequencer #(
  parameter int systolic_size = 8,
  parameter int PIPE_LAT      = 2 * systolic_size,
  parameter int DEPTH         = 128,
  parameter int ROW_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      cfg_base_a,
  input  logic [31:0]      cfg_base_out,
  input  logic [ROW_W-1:0] cfg_rows,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             work,
  output logic             out_in,
  output logic             in_out,
  output logic [31:0]      memory_address_A,
  output logic [31:0]      memory_address_OUT,
  output logic             array_en
`ifdef CL_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stalls
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_a_q, addr_a_d;
  logic [31:0]        addr_out_q, addr_out_d;
  logic [ROW_W-1:0]   rows_q, rows_d;
  logic [ROW_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [ROW_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [PIPE_LAT-1:0] dly_q, dly_d;
  logic [PIPE_LAT-1:0] dly_shift;
  logic               err_q, err_d;
  logic               work_q, work_d;

  logic               active;
  logic               out_in_w;
  logic               in_out_w;
  logic [32:0]        sum_a;
  logic [32:0]        sum_out;
  logic               bounds_bad;

  // Read/write enables are gated by hold in the same cycle so a stalled cycle never touches the BRAM.
  always_comb begin
    active     = (state_q == S_READ) || (state_q == S_DRAIN);
    out_in_w   = (state_q == S_READ) && !hold;
    in_out_w   = active && dly_q[PIPE_LAT-1] && !hold;
    sum_a      = {1'b0, addr_a_q} + {{(33-ROW_W){1'b0}}, rows_q};
    sum_out    = {1'b0, addr_out_q} + {{(33-ROW_W){1'b0}}, rows_q};
    bounds_bad = (sum_a > 33'(DEPTH)) || (sum_out > 33'(DEPTH));
  end

  // The delay line carries each issued read forward; a one-deep line degenerates to the read enable itself.
  generate
    if (PIPE_LAT == 1) begin : g_dly_one
      assign dly_shift = out_in_w;
    end else begin : g_dly_many
      assign dly_shift = {dly_q[PIPE_LAT-2:0], out_in_w};
    end
  endgenerate

  // Next-state logic: configuration latch, bounds check, read issue and write-back tracking.
  always_comb begin
    state_d    = state_q;
    addr_a_d   = addr_a_q;
    addr_out_d = addr_out_q;
    rows_d     = rows_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    dly_d      = dly_q;
    err_d      = err_q;
    work_d     = work_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CHECK;
          addr_a_d   = cfg_base_a;
          addr_out_d = cfg_base_out;
          rows_d     = cfg_rows;
          rd_cnt_d   = '0;
          wr_cnt_d   = '0;
          dly_d      = '0;
          err_d      = 1'b0;
        end
      end
      S_CHECK: begin
        if (bounds_bad) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (rows_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
          work_d  = 1'b1;
        end
      end
      S_READ, S_DRAIN: begin
        if (!hold) begin
          dly_d = dly_shift;
        end
        if (out_in_w) begin
          addr_a_d = addr_a_q + 32'd1;
          rd_cnt_d = rd_cnt_q + ROW_W'(1);
          if (rd_cnt_q == rows_q - ROW_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
        if (in_out_w) begin
          addr_out_d = addr_out_q + 32'd1;
          wr_cnt_d   = wr_cnt_q + ROW_W'(1);
          if (wr_cnt_q == rows_q - ROW_W'(1)) begin
            state_d = S_DONE;
            work_d  = 1'b0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_a_q   <= '0;
      addr_out_q <= '0;
      rows_q     <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      dly_q      <= '0;
      err_q      <= 1'b0;
      work_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_a_q   <= addr_a_d;
      addr_out_q <= addr_out_d;
      rows_q     <= rows_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      dly_q      <= dly_d;
      err_q      <= err_d;
      work_q     <= work_d;
    end
  end

`ifdef CL_SEQ_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_stalls_q;

  // Busy and stalled-cycle counters for the most recent operation; they stop once back in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        perf_cycles_q <= '0;
        perf_stalls_q <= '0;
      end
    end else begin
      perf_cycles_q <= perf_cycles_q + 32'd1;
      if (hold) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

  assign busy               = (state_q != S_IDLE);
  assign done               = (state_q == S_DONE);
  assign err                = err_q;
  assign work               = work_q;
  assign out_in             = out_in_w;
  assign in_out             = in_out_w;
  assign memory_address_A   = addr_a_q;
  assign memory_address_OUT = addr_out_q;
  assign array_en           = busy && !hold && work_q;

endmodule

// File: tb/tb_cl_systolic_sequencer.sv
// tb/tb_cl_systolic_sequencer.sv - self-checking bench for cl_systolic_sequencer
module tb_cl_systolic_sequencer;

  localparam int PL = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] cfg_base_a;
  logic [31:0] cfg_base_out;
  logic [7:0]  cfg_rows;
  logic        hold;
  logic        busy, done, err, work, out_in, in_out, array_en;
  logic [31:0] memory_address_A, memory_address_OUT;

  int n_cmp = 0;
  int n_bad = 0;

  cl_systolic_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .cfg_base_a         (cfg_base_a),
    .cfg_base_out       (cfg_base_out),
    .cfg_rows           (cfg_rows),
    .hold               (hold),
    .busy               (busy),
    .done               (done),
    .err                (err),
    .work               (work),
    .out_in             (out_in),
    .in_out             (in_out),
    .memory_address_A   (memory_address_A),
    .memory_address_OUT (memory_address_OUT),
    .array_en           (array_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
  } ev_t;

  typedef struct {
    int   cyc;
    logic err;
  } dn_t;

  typedef struct {
    logic [31:0] ba;
    logic [31:0] bo;
    int          rows;
    int          hs;
    int          hl;
    int          rst;
    logic        exp_err;
    int          exp_done;
  } vec_t;

  ev_t  rd_q[$];
  ev_t  wr_q[$];
  dn_t  dn_q[$];
  vec_t tv[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit hold_at(input vec_t v, input int rel);
    return (v.hl > 0) && (rel >= v.hs) && (rel < v.hs + v.hl);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_work"}, 32'(work), 0);
    chk({tag, "_out_in"}, 32'(out_in), 0);
    chk({tag, "_in_out"}, 32'(in_out), 0);
    chk({tag, "_addr_a"}, memory_address_A, 0);
    chk({tag, "_addr_out"}, memory_address_OUT, 0);
    chk({tag, "_array_en"}, 32'(array_en), 0);
  endtask

  task automatic run_case(input int i);
    vec_t v;
    int   rcyc[$];
    int   wcyc[$];
    int   t, n, last_wr, limit, exp_ovl, ovl;
    bit   exp_busy, exp_work;
    ev_t  e;
    dn_t  d;
    v = tv[i];
    last_wr = -1;
    exp_ovl = 0;
    ovl = 0;
    rd_q.delete();
    wr_q.delete();
    dn_q.delete();
    if (!v.exp_err && v.rows > 0) begin
      t = 2;
      for (int k = 0; k < v.rows; k++) begin
        while (hold_at(v, t)) t++;
        rcyc.push_back(t);
        if (v.rst < 0 || t <= v.rst) rd_q.push_back('{t, v.ba + 32'(k)});
        t++;
      end
      for (int k = 0; k < v.rows; k++) begin
        t = rcyc[k];
        n = 0;
        while (n < PL) begin
          t++;
          if (!hold_at(v, t)) n++;
        end
        wcyc.push_back(t);
        last_wr = t;
        if (v.rst < 0 || t <= v.rst) wr_q.push_back('{t, v.bo + 32'(k)});
      end
      foreach (rcyc[a]) foreach (wcyc[b]) if (rcyc[a] == wcyc[b]) exp_ovl++;
    end
    if (v.rst < 0) dn_q.push_back('{v.exp_done, v.exp_err});
    limit = (v.rst >= 0) ? v.rst + 30 : v.exp_done + 3;

    for (int rel = 0; rel <= limit; rel++) begin
      @(posedge clk);
      #1;
      start = (rel == 0) || (rel == 4 && rel < v.exp_done) || (rel == v.exp_done) || (rel == v.rst);
      reset = (rel == v.rst);
      hold  = hold_at(v, rel);
      if (rel == 0) begin
        cfg_base_a   = v.ba;
        cfg_base_out = v.bo;
        cfg_rows     = 8'(v.rows);
      end else begin
        cfg_base_a   = $urandom;
        cfg_base_out = $urandom;
        cfg_rows     = 8'($urandom);
      end
      @(negedge clk);
      if (out_in) begin
        if (rd_q.size() == 0) begin
          chk($sformatf("c%0d_rd_unexpected_at_%0d", i, rel), 1, 0);
        end else begin
          e = rd_q.pop_front();
          chk($sformatf("c%0d_rd_cyc", i), rel, e.cyc);
          chk($sformatf("c%0d_rd_addr", i), memory_address_A, e.addr);
        end
      end
      if (in_out) begin
        if (wr_q.size() == 0) begin
          chk($sformatf("c%0d_wr_unexpected_at_%0d", i, rel), 1, 0);
        end else begin
          e = wr_q.pop_front();
          chk($sformatf("c%0d_wr_cyc", i), rel, e.cyc);
          chk($sformatf("c%0d_wr_addr", i), memory_address_OUT, e.addr);
        end
      end
      if (out_in && in_out) ovl++;
      if (done) begin
        if (dn_q.size() == 0) begin
          chk($sformatf("c%0d_done_unexpected_at_%0d", i, rel), 1, 0);
        end else begin
          d = dn_q.pop_front();
          chk($sformatf("c%0d_done_cyc", i), rel, d.cyc);
          chk($sformatf("c%0d_done_err", i), 32'(err), 32'(d.err));
        end
      end
      exp_busy = (rel >= 1) && ((v.rst >= 0) ? rel <= v.rst : rel <= v.exp_done);
      exp_work = (last_wr >= 0) && (rel >= 2) && (rel <= last_wr) && (v.rst < 0 || rel <= v.rst);
      chk($sformatf("c%0d_busy_at_%0d", i, rel), 32'(busy), 32'(exp_busy));
      chk($sformatf("c%0d_work_at_%0d", i, rel), 32'(work), 32'(exp_work));
      chk($sformatf("c%0d_array_en_at_%0d", i, rel), 32'(array_en),
          32'(exp_busy && !hold && exp_work));
      if (v.rst >= 0 && rel == v.rst + 1) check_all_zero($sformatf("c%0d_after_reset", i));
      if (v.rst < 0 && rel == v.exp_done + 1) chk($sformatf("c%0d_err_hold", i), 32'(err), 32'(v.exp_err));
    end
    start = 1'b0;
    reset = 1'b0;
    hold  = 1'b0;
    chk($sformatf("c%0d_reads_left", i), rd_q.size(), 0);
    chk($sformatf("c%0d_writes_left", i), wr_q.size(), 0);
    chk($sformatf("c%0d_done_left", i), dn_q.size(), 0);
    chk($sformatf("c%0d_overlap", i), ovl, exp_ovl);
  endtask

  initial begin
    tv[0]  = '{32'd0,          32'd64,  8,   0,  0, -1, 1'b0, 26};
    tv[1]  = '{32'd10,         32'd80,  20,  0,  0, -1, 1'b0, 38};
    tv[2]  = '{32'd0,          32'd0,   0,   1,  1, -1, 1'b0, 2};
    tv[3]  = '{32'd0,          32'd120, 16,  0,  0, -1, 1'b1, 2};
    tv[4]  = '{32'd0,          32'd64,  8,   5,  3, -1, 1'b0, 29};
    tv[5]  = '{32'd0,          32'd64,  8,   0,  0, 10, 1'b0, 0};
    tv[6]  = '{32'd3,          32'd100, 8,   0,  0, -1, 1'b0, 26};
    tv[7]  = '{32'd127,        32'd0,   1,   0,  0, -1, 1'b0, 19};
    tv[8]  = '{32'd128,        32'd0,   1,   0,  0, -1, 1'b1, 2};
    tv[9]  = '{32'd0,          32'd0,   128, 0,  0, -1, 1'b0, 146};
    tv[10] = '{32'd0,          32'd64,  8,   15, 2, -1, 1'b0, 28};
    tv[11] = '{32'hFFFF_FFF0,  32'd0,   32,  0,  0, -1, 1'b1, 2};

    reset        = 1'b1;
    start        = 1'b1;
    hold         = 1'b0;
    cfg_base_a   = 32'd5;
    cfg_base_out = 32'd6;
    cfg_rows     = 8'd4;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_all_zero($sformatf("reset_%0d", c));
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset_idle");

    for (int i = 0; i < 12; i++) run_case(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
